// File: rtl/sprite_collision_matrix.sv
// Purpose : all-pairs collision detector for N_OBJ axis-aligned rectangles, with
//           per-pair overlap, enter/exit pulses, sticky hit bits and bounce axis.
// Latency : valid_i in cycle t -> valid_o and results in cycle t+2; no backpressure,
//           accepts one sample per cycle.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i               sample strobe; en_i and coordinates are captured with it
//   en_i[N_OBJ]           per-object enable (disabled objects collide with nothing)
//   left_i/right_i        packed x edges, object i at [i*X_W +: X_W]
//   top_i/bottom_i        packed y edges, object i at [i*Y_W +: Y_W]
//   clr_i[P]              per-pair sticky clear, acts every cycle
//   valid_o               one-cycle pulse marking a fresh result
//   overlap_o/axis_x_o    current overlap and "x penetration shallower" per pair
//   enter_o/exit_o        0->1 / 1->0 overlap transition pulses
//   sticky_o              set by enter_o, cleared by clr_i (set wins)
//
// Pair k enumerates (i,j), i<j, lexicographically: (0,1),(0,2)..(0,N-1),(1,2)..

`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module sprite_collision_matrix #(
    parameter  int N_OBJ = 3,
    parameter  int X_W   = `X_POS_W,
    parameter  int Y_W   = `Y_POS_W,
    localparam int P     = N_OBJ * (N_OBJ - 1) / 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [N_OBJ-1:0]     en_i,
    input  logic [N_OBJ*X_W-1:0] left_i,
    input  logic [N_OBJ*X_W-1:0] right_i,
    input  logic [N_OBJ*Y_W-1:0] top_i,
    input  logic [N_OBJ*Y_W-1:0] bottom_i,
    input  logic [P-1:0]         clr_i,
    output logic                 valid_o,
    output logic [P-1:0]         overlap_o,
    output logic [P-1:0]         enter_o,
    output logic [P-1:0]         exit_o,
    output logic [P-1:0]         sticky_o,
    output logic [P-1:0]         axis_x_o
);

    // Depths are compared at the wider of the two coordinate widths.
    localparam int D_W = (X_W > Y_W) ? X_W : Y_W;

    logic         r_s1_vld;
    logic [P-1:0] w_ov;
    logic [P-1:0] w_ax;

    logic         r_vld;
    logic [P-1:0] r_ov;
    logic [P-1:0] r_ax;
    logic [P-1:0] r_enter;
    logic [P-1:0] r_exit;
    logic [P-1:0] r_sticky;

    // Stage-1 valid follows the strobe every cycle; data below only loads on valid_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= valid_i;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_OBJ; gi++) begin : g_i
            for (gj = gi + 1; gj < N_OBJ; gj++) begin : g_j
                localparam int K = gi * (2 * N_OBJ - gi - 1) / 2 + (gj - gi - 1);

                logic [X_W-1:0] w_li, w_lj, w_ri, w_rj, w_ox;
                logic [Y_W-1:0] w_ti, w_tj, w_bi, w_bj, w_oy;
                logic [D_W-1:0] w_ox_ext, w_oy_ext;

                logic [3:0]     r_cmp;
                logic           r_en;
                logic [X_W-1:0] r_ox;
                logic [Y_W-1:0] r_oy;

                assign w_li = left_i  [gi*X_W +: X_W];
                assign w_lj = left_i  [gj*X_W +: X_W];
                assign w_ri = right_i [gi*X_W +: X_W];
                assign w_rj = right_i [gj*X_W +: X_W];
                assign w_ti = top_i   [gi*Y_W +: Y_W];
                assign w_tj = top_i   [gj*Y_W +: Y_W];
                assign w_bi = bottom_i[gi*Y_W +: Y_W];
                assign w_bj = bottom_i[gj*Y_W +: Y_W];

                // Depth may wrap when the pair does not overlap; axis is gated by
                // overlap so the wrapped value is never used.
                assign w_ox = ((w_ri < w_rj) ? w_ri : w_rj) - ((w_li > w_lj) ? w_li : w_lj);
                assign w_oy = ((w_bi < w_bj) ? w_bi : w_bj) - ((w_ti > w_tj) ? w_ti : w_tj);

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_cmp <= '0;
                        r_en  <= 1'b0;
                        r_ox  <= '0;
                        r_oy  <= '0;
                    end else if (valid_i) begin
                        r_cmp <= {w_ri > w_lj, w_rj > w_li, w_bj > w_ti, w_bi > w_tj};
                        // The four cross compares alone accept a rectangle whose edges
                        // are inverted, so each object's own extent is also required
                        // to be non-empty; this is folded into the enable term.
                        r_en  <= en_i[gi] & en_i[gj]
                                 & (w_ri > w_li) & (w_rj > w_lj)
                                 & (w_bi > w_ti) & (w_bj > w_tj);
                        r_ox  <= w_ox;
                        r_oy  <= w_oy;
                    end
                end

                assign w_ox_ext = D_W'(r_ox);
                assign w_oy_ext = D_W'(r_oy);

                assign w_ov[K] = r_en & (&r_cmp);
                // Tie resolves to vertical bounce (0).
                assign w_ax[K] = w_ov[K] & (w_ox_ext < w_oy_ext);
            end
        end
    endgenerate

    // Stage 2: r_ov doubles as the "previous overlap" for edge detection, so it
    // only advances on valid results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld    <= 1'b0;
            r_ov     <= '0;
            r_ax     <= '0;
            r_enter  <= '0;
            r_exit   <= '0;
            r_sticky <= '0;
        end else begin
            // Uses the enter pulse currently on the output, so a clear in the
            // same cycle as an enter pulse loses to the set.
            r_sticky <= (r_sticky & ~clr_i) | r_enter;
            if (r_s1_vld) begin
                r_vld   <= 1'b1;
                r_ov    <= w_ov;
                r_ax    <= w_ax;
                r_enter <= w_ov & ~r_ov;
                r_exit  <= ~w_ov & r_ov;
            end else begin
                r_vld   <= 1'b0;
                r_enter <= '0;
                r_exit  <= '0;
            end
        end
    end

    assign valid_o   = r_vld;
    assign overlap_o = r_ov;
    assign axis_x_o  = r_ax;
    assign enter_o   = r_enter;
    assign exit_o    = r_exit;
    assign sticky_o  = r_sticky;

endmodule

// File: tb/tb_sprite_collision_matrix.sv
// Bench for sprite_collision_matrix (N_OBJ=3, X_W=8, Y_W=7): directed vector table,
// hand-written multi-cycle sequences and a randomized run, all compared every cycle
// against an interval-arithmetic reference with a result queue for the 2-cycle latency.

module tb_sprite_collision_matrix;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int P  = 3;

    logic            clk    = 1'b0;
    logic            rst    = 1'b0;
    logic            valid  = 1'b0;
    logic [N-1:0]    en     = '1;
    logic [N*XW-1:0] left   = '0;
    logic [N*XW-1:0] right  = '0;
    logic [N*YW-1:0] top    = '0;
    logic [N*YW-1:0] bottom = '0;
    logic [P-1:0]    clr    = '0;

    logic            valid_o;
    logic [P-1:0]    overlap_o, enter_o, exit_o, sticky_o, axis_o;

    always #5 clk = ~clk;

    sprite_collision_matrix #(.N_OBJ(N), .X_W(XW), .Y_W(YW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .en_i     (en),
        .left_i   (left),
        .right_i  (right),
        .top_i    (top),
        .bottom_i (bottom),
        .clr_i    (clr),
        .valid_o  (valid_o),
        .overlap_o(overlap_o),
        .enter_o  (enter_o),
        .exit_o   (exit_o),
        .sticky_o (sticky_o),
        .axis_x_o (axis_o)
    );

    typedef struct packed {
        logic [2:0]        en;
        logic [2:0][7:0]   l;
        logic [2:0][7:0]   r;
        logic [2:0][6:0]   t;
        logic [2:0][6:0]   b;
        logic [2:0]        ov;
        logic [2:0]        ax;
        logic [2:0]        ent;
        logic [2:0]        ext;
    } vec_t;

    typedef struct packed {
        logic [P-1:0] ov;
        logic [P-1:0] ax;
    } res_t;

    typedef struct {
        res_t r;
        int   due;
    } pend_t;

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;

    pend_t        q[$];
    logic [P-1:0] m_ov, m_ax, m_ent, m_ext, m_sticky;
    logic         m_vld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: two rectangles share a pixel iff both interval intersections are
    // non-empty, i.e. the signed depths are positive. Empty rectangles fall out
    // naturally since their own extent bounds the depth.
    function automatic res_t ref_model();
        res_t res;
        int   k;
        res = '0;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                int li, lj, ri, rj, ti, tj, bi, bj, ox, oy;
                bit ov;
                li = int'(left  [i*XW +: XW]);  lj = int'(left  [j*XW +: XW]);
                ri = int'(right [i*XW +: XW]);  rj = int'(right [j*XW +: XW]);
                ti = int'(top   [i*YW +: YW]);  tj = int'(top   [j*YW +: YW]);
                bi = int'(bottom[i*YW +: YW]);  bj = int'(bottom[j*YW +: YW]);
                ox = ((ri < rj) ? ri : rj) - ((li > lj) ? li : lj);
                oy = ((bi < bj) ? bi : bj) - ((ti > tj) ? ti : tj);
                ov = en[i] && en[j] && (ox > 0) && (oy > 0);
                res.ov[k] = ov;
                res.ax[k] = ov && (ox < oy);
                k++;
            end
        end
        return res;
    endfunction

    task automatic model_clear();
        m_ov = '0; m_ax = '0; m_ent = '0; m_ext = '0; m_sticky = '0; m_vld = 1'b0;
        q.delete();
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_valid"},   32'(valid_o),   32'(m_vld));
        check({tag, "_overlap"}, 32'(overlap_o), 32'(m_ov));
        check({tag, "_axis"},    32'(axis_o),    32'(m_ax));
        check({tag, "_enter"},   32'(enter_o),   32'(m_ent));
        check({tag, "_exit"},    32'(exit_o),    32'(m_ext));
        check({tag, "_sticky"},  32'(sticky_o),  32'(m_sticky));
    endtask

    // One clock: advance the model with the inputs present at this edge, then compare.
    task automatic step();
        pend_t p;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst) begin
            model_clear();
        end else begin
            m_sticky = (m_sticky & ~clr) | m_ent;
            if (q.size() > 0 && q[0].due == edge_n) begin
                p     = q.pop_front();
                m_ent = p.r.ov & ~m_ov;
                m_ext = ~p.r.ov & m_ov;
                m_ov  = p.r.ov;
                m_ax  = p.r.ax;
                m_vld = 1'b1;
            end else begin
                m_ent = '0;
                m_ext = '0;
                m_vld = 1'b0;
            end
            if (valid) begin
                p.r   = ref_model();
                p.due = edge_n + 1;
                q.push_back(p);
            end
        end
        compare_all("cyc");
    endtask

    task automatic drive(input vec_t v, input logic vld, input logic [P-1:0] c);
        en     = v.en;
        left   = v.l;
        right  = v.r;
        top    = v.t;
        bottom = v.b;
        valid  = vld;
        clr    = c;
    endtask

    task automatic idle();
        valid = 1'b0;
        clr   = '0;
    endtask

    function automatic vec_t mk(input logic [2:0] en_v,
                                input int l0, input int r0, input int t0, input int b0,
                                input int l1, input int r1, input int t1, input int b1,
                                input int l2, input int r2, input int t2, input int b2,
                                input logic [2:0] ov, input logic [2:0] ax,
                                input logic [2:0] ent, input logic [2:0] ext);
        vec_t v;
        v.en = en_v;
        v.l[0] = 8'(l0); v.r[0] = 8'(r0); v.t[0] = 7'(t0); v.b[0] = 7'(b0);
        v.l[1] = 8'(l1); v.r[1] = 8'(r1); v.t[1] = 7'(t1); v.b[1] = 7'(b1);
        v.l[2] = 8'(l2); v.r[2] = 8'(r2); v.t[2] = 7'(t2); v.b[2] = 7'(b2);
        v.ov = ov; v.ax = ax; v.ent = ent; v.ext = ext;
        return v;
    endfunction

    initial begin
        vec_t tbl[11];

        //            en       obj0 l  r  t  b     obj1 l  r  t  b     obj2 l  r  t  b      ov      ax      enter   exit
        tbl[0]  = mk(3'b111,  10, 20, 10, 20,  15, 25, 12, 30,  50, 60, 50, 60, 3'b001, 3'b001, 3'b001, 3'b000);
        tbl[1]  = mk(3'b111,  10, 20, 10, 20,  15, 25, 12, 30,  50, 60, 50, 60, 3'b001, 3'b001, 3'b000, 3'b000);
        tbl[2]  = mk(3'b111,  10, 20, 10, 20,  20, 25, 12, 30,  50, 60, 50, 60, 3'b000, 3'b000, 3'b000, 3'b001);
        tbl[3]  = mk(3'b111,  10, 20, 10, 20,  20, 25, 10, 20,  10, 20, 20, 30, 3'b000, 3'b000, 3'b000, 3'b000);
        tbl[4]  = mk(3'b111,  10, 20, 10, 20,  16, 30, 16, 30,  50, 60, 50, 60, 3'b001, 3'b000, 3'b001, 3'b000);
        tbl[5]  = mk(3'b101,  10, 20, 10, 20,  16, 30, 16, 30,  50, 60, 50, 60, 3'b000, 3'b000, 3'b000, 3'b001);
        tbl[6]  = mk(3'b111,  10, 20, 10, 20,  12, 30, 18, 30,  50, 60, 50, 60, 3'b001, 3'b000, 3'b001, 3'b000);
        tbl[7]  = mk(3'b111,  10, 20, 10, 20,  12, 30, 18, 30,  28, 40,  5, 25, 3'b101, 3'b100, 3'b100, 3'b000);
        tbl[8]  = mk(3'b111,  15, 15, 10, 20,  12, 30, 18, 30,  28, 40,  5, 25, 3'b100, 3'b100, 3'b000, 3'b001);
        tbl[9]  = mk(3'b111,   5, 40, 25, 20,  12, 30, 18, 30,  28, 40,  5, 25, 3'b100, 3'b100, 3'b000, 3'b000);
        tbl[10] = mk(3'b111,   0,200,  0,100,  10,250, 10,100, 250,255,110,120, 3'b001, 3'b000, 3'b001, 3'b100);

        model_clear();

        // Reset state.
        #1 rst = 1'b1;
        #2;
        compare_all("reset");
        step();
        step();
        #2 rst = 1'b0;
        step();

        // Directed table: one sample, result checked two edges later, one idle cycle.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i], 1'b1, '0);
            step();
            idle();
            step();
            check($sformatf("tbl%0d_valid", i),   32'(valid_o),   32'd1);
            check($sformatf("tbl%0d_overlap", i), 32'(overlap_o), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_axis", i),    32'(axis_o),    32'(tbl[i].ax));
            check($sformatf("tbl%0d_enter", i),   32'(enter_o),   32'(tbl[i].ent));
            check($sformatf("tbl%0d_exit", i),    32'(exit_o),    32'(tbl[i].ext));
            step();
        end

        // Sticky: clear all, then clear pair 0 in the very cycle its enter pulse shows.
        clr = 3'b111;
        step();
        clr = '0;
        check("sticky_clear_all", 32'(sticky_o), 32'd0);
        drive(tbl[2], 1'b1, '0); step(); idle(); step(); step();
        drive(tbl[0], 1'b1, '0); step(); idle(); step();
        check("sticky_seq_enter", 32'(enter_o), 32'b001);
        clr = 3'b001;
        step();
        check("sticky_set_wins", 32'(sticky_o[0]), 32'd1);
        step();
        clr = '0;
        check("sticky_cleared", 32'(sticky_o[0]), 32'd0);

        // Back-to-back: no-overlap/overlap alternating on four consecutive strobes.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(((c % 2) == 0) ? tbl[2] : tbl[0], 1'b1, '0);
            else       idle();
            step();
            if (c >= 1 && c <= 4) begin
                check($sformatf("b2b%0d_valid", c), 32'(valid_o), 32'd1);
                check($sformatf("b2b%0d_enter", c), 32'(enter_o), (((c - 1) % 2) == 1) ? 32'b001 : 32'd0);
                check($sformatf("b2b%0d_exit", c),  32'(exit_o),  (((c - 1) % 2) == 0) ? 32'b001 : 32'd0);
            end else begin
                check($sformatf("b2b%0d_valid", c), 32'(valid_o), 32'd0);
            end
        end

        // Asynchronous reset with a sample in flight.
        drive(tbl[0], 1'b1, '0);
        step();
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_overlap", 32'(overlap_o), 32'd0);
        check("arst_sticky",  32'(sticky_o),  32'd0);
        check("arst_axis",    32'(axis_o),    32'd0);
        check("arst_valid",   32'(valid_o),   32'd0);
        model_clear();
        step();
        step();
        #2 rst = 1'b0;
        step();
        check("arst_no_valid_a", 32'(valid_o), 32'd0);
        step();
        check("arst_no_valid_b", 32'(valid_o), 32'd0);
        drive(tbl[0], 1'b1, '0);
        step();
        idle();
        step();
        check("arst_first_enter", 32'(enter_o), 32'b001);
        step();

        // Randomized run against the reference.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                int lo, tp;
                if ((c % 8) == 7) begin
                    left  [i*XW +: XW] = 8'($urandom);
                    right [i*XW +: XW] = 8'($urandom);
                    top   [i*YW +: YW] = 7'($urandom);
                    bottom[i*YW +: YW] = 7'($urandom);
                end else begin
                    lo = int'($urandom_range(0, 60));
                    tp = int'($urandom_range(0, 60));
                    left  [i*XW +: XW] = 8'(lo);
                    right [i*XW +: XW] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 60))
                                                                       : 8'(lo + int'($urandom_range(1, 30)));
                    top   [i*YW +: YW] = 7'(tp);
                    bottom[i*YW +: YW] = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 60))
                                                                       : 7'(tp + int'($urandom_range(1, 30)));
                end
            end
            en    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            valid = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            step();
        end
        idle();
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
